// File: rtl/game_pkg.sv
// Game-state codes shared by the flow controller, VGA and snake units.
package game_pkg;
    localparam int GS_W = 3;

    localparam logic [GS_W-1:0] GS_RESTART = 3'd0;
    localparam logic [GS_W-1:0] GS_START   = 3'd1;
    localparam logic [GS_W-1:0] GS_PLAY    = 3'd2;
    localparam logic [GS_W-1:0] GS_DIE     = 3'd3;
    localparam logic [GS_W-1:0] GS_PAUSE   = 3'd4;
    localparam logic [GS_W-1:0] GS_OVER    = 3'd5;
endpackage

// File: rtl/die_flash_gen.sv
// Death-flash generator: times the DIE dwell and blinks the snake on odd half-periods.
// Registered die_flash; done is high on the last dwell cycle. No backpressure.
module die_flash_gen #(
    parameter int FLASH_HALF_CYC = 25_000_000,
    parameter int FLASH_TOGGLES  = 6,
    parameter int DIE_HOLD_CYC   = 200_000_000,
    parameter int CNT_W          = 32
) (
    input  logic CLK_50M,
    input  logic RSTn,
    input  logic en,
    output logic die_flash,
    output logic done
);
    localparam int HW = $clog2(FLASH_HALF_CYC + 1);
    localparam int KW = $clog2(FLASH_TOGGLES + 1);

    logic [CNT_W-1:0] dwell_cnt;
    logic [HW-1:0]    half_cnt;
    logic [KW-1:0]    half_idx;
    logic [KW-1:0]    idx_nxt;
    logic             half_wrap;

    assign done      = en && (dwell_cnt == CNT_W'(DIE_HOLD_CYC - 1));
    assign half_wrap = (half_cnt == HW'(FLASH_HALF_CYC - 1));
    // Half-period index saturates once flashing is over, keeping it narrow.
    assign idx_nxt   = (half_wrap && (half_idx < KW'(FLASH_TOGGLES))) ? half_idx + KW'(1) : half_idx;

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            dwell_cnt <= '0;
            half_cnt  <= '0;
            half_idx  <= '0;
            die_flash <= 1'b1;
        end else if (!en || done) begin
            dwell_cnt <= '0;
            half_cnt  <= '0;
            half_idx  <= '0;
            die_flash <= 1'b1;
        end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
            half_cnt  <= half_wrap ? '0 : half_cnt + HW'(1);
            half_idx  <= idx_nxt;
            die_flash <= !(idx_nxt[0] && (idx_nxt < KW'(FLASH_TOGGLES)));
        end
    end
endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow FSM: start/play/pause/die/over/restart with lives and restart/respawn pulses.
// All outputs registered, one cycle after the triggering input. No backpressure.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int N_KEYS         = 4,
    parameter int LIVES          = 3,
    parameter int FLASH_HALF_CYC = 25_000_000,
    parameter int FLASH_TOGGLES  = 6,
    parameter int DIE_HOLD_CYC   = 200_000_000,
    parameter int RESTART_CYC    = 6,
    parameter int CNT_W          = 32
) (
    input  logic              CLK_50M,
    input  logic              RSTn,
    input  logic [N_KEYS-1:0] key_press,
    input  logic              pause_press,
    input  logic              hit_wall,
    input  logic              hit_body,
    output logic [GS_W-1:0]   game_status,
    output logic [3:0]        lives_left,
    output logic              die_flash,
    output logic              restart,
    output logic              respawn
);
    localparam int RW = $clog2(RESTART_CYC + 1);

    logic [GS_W-1:0] state_q, state_nxt;
    logic [RW-1:0]   rst_cnt, rst_cnt_nxt;
    logic [3:0]      lives_nxt;
    logic            restart_nxt, respawn_nxt;
    logic            die_done, any_key, hit;

    assign any_key     = |key_press;
    assign hit         = hit_wall | hit_body;
    assign game_status = state_q;

    die_flash_gen #(
        .FLASH_HALF_CYC (FLASH_HALF_CYC),
        .FLASH_TOGGLES  (FLASH_TOGGLES),
        .DIE_HOLD_CYC   (DIE_HOLD_CYC),
        .CNT_W          (CNT_W)
    ) u_flash (
        .CLK_50M   (CLK_50M),
        .RSTn      (RSTn),
        .en        (state_q == GS_DIE),
        .die_flash (die_flash),
        .done      (die_done)
    );

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) state_q <= GS_START;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            GS_START:   if (any_key) state_nxt = GS_PLAY;
            GS_PLAY: begin
                if (hit)              state_nxt = GS_DIE;
                else if (pause_press) state_nxt = GS_PAUSE;
            end
            GS_PAUSE:   if (pause_press) state_nxt = GS_PLAY;
            GS_DIE:     if (die_done) state_nxt = (lives_left != 4'd0) ? GS_START : GS_OVER;
            GS_OVER:    if (any_key) state_nxt = GS_RESTART;
            GS_RESTART: if (rst_cnt == RW'(RESTART_CYC - 1)) state_nxt = GS_START;
            default:    state_nxt = GS_START;
        endcase
    end

    always_comb begin
        restart_nxt = (state_nxt == GS_RESTART);
        respawn_nxt = (state_q == GS_DIE) && (state_nxt == GS_START);
        rst_cnt_nxt = (state_q == GS_RESTART) ? rst_cnt + RW'(1) : '0;
        lives_nxt   = lives_left;
        if (state_q == GS_PLAY && hit)
            lives_nxt = (lives_left == 4'd0) ? 4'd0 : lives_left - 4'd1;
        else if (state_q == GS_OVER && any_key)
            lives_nxt = 4'(LIVES);
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            lives_left <= 4'(LIVES);
            restart    <= 1'b0;
            respawn    <= 1'b0;
            rst_cnt    <= '0;
        end else begin
            lives_left <= lives_nxt;
            restart    <= restart_nxt;
            respawn    <= respawn_nxt;
            rst_cnt    <= rst_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios then random stimulus against a behavioural model.
module tb_game_flow_ctrl;
    localparam int LIVES = 2;
    localparam int HALF  = 4;
    localparam int TOG   = 6;
    localparam int HOLD  = 32;
    localparam int RC    = 6;

    logic       CLK_50M = 1'b0;
    logic       RSTn = 1'b0;
    logic [3:0] key_press = 4'd0;
    logic       pause_press = 1'b0;
    logic       hit_wall = 1'b0;
    logic       hit_body = 1'b0;
    logic [2:0] game_status;
    logic [3:0] lives_left;
    logic       die_flash, restart, respawn;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Behavioural model: state code, lives, cycles spent in DIE, cycles spent in RESTART.
    int m_st, m_lives, m_dwell, m_rc, m_respawn;

    always #5 CLK_50M = ~CLK_50M;

    game_flow_ctrl #(
        .N_KEYS(4), .LIVES(LIVES), .FLASH_HALF_CYC(HALF), .FLASH_TOGGLES(TOG),
        .DIE_HOLD_CYC(HOLD), .RESTART_CYC(RC), .CNT_W(32)
    ) dut (
        .CLK_50M(CLK_50M), .RSTn(RSTn), .key_press(key_press), .pause_press(pause_press),
        .hit_wall(hit_wall), .hit_body(hit_body), .game_status(game_status),
        .lives_left(lives_left), .die_flash(die_flash), .restart(restart), .respawn(respawn)
    );

    task automatic chk(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int flash_of(input int d);
        int k;
        k = d / HALF;
        return ((k % 2 == 1) && (k < TOG)) ? 0 : 1;
    endfunction

    task automatic model_reset();
        m_st = 1; m_lives = LIVES; m_dwell = 0; m_rc = 0; m_respawn = 0;
    endtask

    task automatic model_step(input int key, input int pause, input int hit);
        int prev;
        prev = m_st;
        case (m_st)
            1: if (key != 0) m_st = 2;
            2: begin
                if (hit != 0) begin
                    m_st = 3; m_dwell = 0;
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                end else if (pause != 0) m_st = 4;
            end
            4: if (pause != 0) m_st = 2;
            3: begin
                if (m_dwell == HOLD - 1) m_st = (m_lives != 0) ? 1 : 5;
                else m_dwell++;
            end
            5: if (key != 0) begin m_st = 0; m_rc = 0; m_lives = LIVES; end
            0: begin
                if (m_rc == RC - 1) m_st = 1;
                else m_rc++;
            end
            default: m_st = 1;
        endcase
        m_respawn = (prev == 3 && m_st == 1) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("game_status", int'(game_status), m_st);
        chk("lives_left", int'(lives_left), m_lives);
        chk("die_flash", int'(die_flash), (m_st == 3) ? flash_of(m_dwell) : 1);
        chk("restart", int'(restart), (m_st == 0) ? 1 : 0);
        chk("respawn", int'(respawn), m_respawn);
    endtask

    // Called right after a negedge; inputs are held across the following posedge.
    task automatic tick(input logic [3:0] k, input logic p, input logic w, input logic b);
        key_press = k; pause_press = p; hit_wall = w; hit_body = b;
        @(posedge CLK_50M);
        model_step(int'(k != 4'd0), int'(p), int'(w | b));
        @(negedge CLK_50M);
        check_all();
    endtask

    task automatic async_reset();
        RSTn = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        RSTn = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge CLK_50M);
        check_all();
        RSTn = 1'b1;

        // Start, die with a life to spare, respawn.
        tick(4'b0010, 0, 0, 0);
        chk("play_after_key", int'(game_status), 2);
        tick(4'd0, 0, 1, 0);
        chk("lives_after_hit1", int'(lives_left), 1);
        for (int i = 0; i < HOLD; i++) tick(4'd0, 0, 0, 0);
        chk("respawn_pulse", int'(respawn), 1);
        chk("start_after_die", int'(game_status), 1);

        // Last life lost, game over, restart.
        tick(4'b0001, 0, 0, 0);
        tick(4'd0, 0, 0, 1);
        for (int i = 0; i < HOLD; i++) tick(4'd0, 0, 0, 0);
        chk("over_state", int'(game_status), 5);
        chk("over_no_respawn", int'(respawn), 0);
        tick(4'b1000, 0, 0, 0);
        chk("restart_high", int'(restart), 1);
        for (int i = 0; i < RC; i++) tick(4'd0, 0, 0, 0);
        chk("start_after_restart", int'(game_status), 1);
        chk("lives_reloaded", int'(lives_left), LIVES);

        // Pause ignores hits; hit beats pause in the same cycle.
        tick(4'b0100, 0, 0, 0);
        tick(4'd0, 1, 0, 0);
        for (int i = 0; i < 10; i++) tick(4'd0, 0, 0, 1);
        chk("pause_holds", int'(game_status), 4);
        tick(4'd0, 1, 0, 0);
        tick(4'd0, 1, 1, 0);
        chk("hit_beats_pause", int'(game_status), 3);

        // Reset in the middle of DIE.
        for (int i = 0; i < 10; i++) tick(4'd0, 0, 0, 0);
        async_reset();

        // Random phase.
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] k;
            logic p, w, b;
            k = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            p = ($urandom_range(0, 7) == 0);
            w = ($urandom_range(0, 24) == 0);
            b = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
            else tick(k, p, w, b);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-flow controller that sequences the game through start, play, pause, death, game-over and restart. It adds a lives counter, a pause mode and a configurable death-flash generator. It sits between the key debouncers and collision detectors on one side and the snake-move, score and VGA units on the other. It drives `game_status`, `die_flash`, `restart` and a per-life `respawn` pulse.

## Interface
- `N_KEYS`, 4, number of direction key-press inputs.
- `LIVES`, 3, lives per game; legal range 1..15.
- `FLASH_HALF_CYC`, 25_000_000, length of one flash half-period in clocks.
- `FLASH_TOGGLES`, 6, number of flash half-periods; must be even.
- `DIE_HOLD_CYC`, 200_000_000, total DIE dwell in clocks; must be ≥ `FLASH_HALF_CYC*FLASH_TOGGLES`.
- `RESTART_CYC`, 6, number of clocks `restart` is held high.
- `CNT_W`, 32, width of the dwell counter; must hold `DIE_HOLD_CYC`.

Ports:
- `CLK_50M` in 1: system clock.
- `RSTn` in 1: reset. One clock; reset is asynchronous and active-low.
- `key_press` in N_KEYS: single-cycle press pulses, already debounced.
- `pause_press` in 1: single-cycle pause/resume pulse.
- `hit_wall` in 1: collision with a wall, level-sensitive.
- `hit_body` in 1: self-collision, level-sensitive.
- `game_status` out 3: current state code (see Operation).
- `lives_left` out 4: remaining lives.
- `die_flash` out 1: display enable; a low level blanks the snake.
- `restart` out 1: full-game reset request to downstream units.
- `respawn` out 1: one-cycle pulse; repositions the snake and keeps the score.

## Operation
- State codes:
  - RESTART=0
  - START=1
  - PLAY=2
  - DIE=3
  - PAUSE=4
  - OVER=5
- Reset values:
  - `game_status`=START, `lives_left`=LIVES.
  - `die_flash`=1, `restart`=0, `respawn`=0.
  - Internal counters = 0.
- START:
  - Any bit of `key_press` moves to PLAY.
  - `pause_press` and the hit inputs are ignored.
- PLAY:
  - `hit_wall|hit_body` moves to DIE and decrements `lives_left` by 1, saturating at 0.
  - Otherwise `pause_press` moves to PAUSE.
  - A hit takes priority over `pause_press` in the same cycle.
- PAUSE:
  - `pause_press` returns to PLAY.
  - Keys and hits are ignored.
- DIE:
  - The dwell counter runs 0..DIE_HOLD_CYC-1.
  - Half-period index k = counter / FLASH_HALF_CYC, tracked by a separate counter; no divider.
  - `die_flash`=0 while k is odd and k < FLASH_TOGGLES; otherwise 1.
  - On the last dwell cycle: counter clears and `die_flash`=1.
  - If `lives_left`≠0: `respawn` pulses for 1 cycle and the state goes to START.
  - If `lives_left`=0: the state goes to OVER.
- OVER:
  - `die_flash`=1.
  - Any `key_press` moves to RESTART and reloads `lives_left`=LIVES.
- RESTART:
  - `restart`=1 for exactly RESTART_CYC clocks, then `restart`=0 and the state goes to START.
- Illegal state codes 6 and 7 recover to START on the next clock.
- All outputs are registered. No combinational path from any input to any output.

## Timing
- Each transition takes effect on the clock edge that samples the triggering input; `game_status` changes 1 cycle after the input.
- Lives decrement occurs on the same edge as the PLAY→DIE transition.
- Flash timing, with the counter =0 on the first DIE cycle: `die_flash` falls on the edge where the counter reaches FLASH_HALF_CYC and rises at 2·FLASH_HALF_CYC. This repeats up to FLASH_TOGGLES half-periods.
- DIE lasts exactly DIE_HOLD_CYC cycles in DIE.
- `respawn` is high in the first START cycle after DIE.
- `restart` is high on every RESTART cycle. RESTART lasts exactly RESTART_CYC cycles.
- Asserting `RSTn` low in any state, including mid-DIE or mid-RESTART, immediately forces the reset values.

## Structure
- Shared package `game_pkg`: state-code localparams (GS_RESTART..GS_OVER) and `GS_W`=3. The VGA and snake units use the same package.
- Sub-module `die_flash_gen`:
  - Inputs: `CLK_50M`, `RSTn`, `en` (state==DIE).
  - Parameters: FLASH_HALF_CYC, FLASH_TOGGLES, DIE_HOLD_CYC.
  - Outputs: `die_flash` and a `done` pulse on the last dwell cycle.
  - Clears its counters whenever `en` is low.
- The top level holds the FSM, the lives register and the restart counter.

## Test plan
Bench parameters: LIVES=2, FLASH_HALF_CYC=4, FLASH_TOGGLES=6, DIE_HOLD_CYC=32, RESTART_CYC=6.

- Release reset, then `key_press`=4'b0010 → `game_status` 1→2 next cycle; `lives_left`=2, `die_flash`=1.
- In PLAY, pulse `hit_wall` → DIE and `lives_left`=1. `die_flash` is low for counter ranges 4-7, 12-15 and 20-23, and high otherwise. After 32 DIE cycles: START with `respawn` high for 1 cycle.
- Second hit → `lives_left`=0; after 32 cycles → OVER (5) with no `respawn`. A key press then gives RESTART, `restart` high for 6 cycles, then START with `lives_left`=2.
- PLAY + `pause_press` → PAUSE (4); `hit_body` held 10 cycles → no change. `pause_press` → PLAY. `pause_press` and `hit_wall` in the same cycle → DIE.
- `RSTn` low at DIE counter=10 → immediately START, `lives_left`=2, `die_flash`=1, `respawn`=0.
